// File: rtl/sayeh_pkg.sv
// sayeh_pkg: shared definitions for the SAYEH control unit.
//   - FSM state encoding (legacy-compatible 3-bit constants)
//   - opcode / sub-opcode constants and instruction field bit positions
//   - ctrl_t: packed bundle of every datapath and bus strobe
//   - small decode helpers used by the decoder
package sayeh_pkg;

    // FSM states
    localparam logic [2:0] ST_RST    = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_EXEC   = 3'd3;
    localparam logic [2:0] ST_MEMX   = 3'd4;
    localparam logic [2:0] ST_HALT   = 3'd5;

    // Instruction field bit positions
    localparam int OPC_MSB     = 15;
    localparam int OPC_LSB     = 12;
    localparam int SYS_SUB_MSB = 11;
    localparam int SYS_SUB_LSB = 8;
    localparam int IMM_SUB_MSB = 9;
    localparam int IMM_SUB_LSB = 8;
    localparam int IMM_MSB     = 7;
    localparam int IMM_LSB     = 0;

    // Major opcodes
    localparam logic [3:0] OP_SYS = 4'h0;
    localparam logic [3:0] OP_MVR = 4'h1;
    localparam logic [3:0] OP_LDA = 4'h2;
    localparam logic [3:0] OP_STA = 4'h3;
    localparam logic [3:0] OP_INP = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_ORR = 4'h7;
    localparam logic [3:0] OP_NOT = 4'h8;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_SHR = 4'hA;
    localparam logic [3:0] OP_ADD = 4'hB;
    localparam logic [3:0] OP_SUB = 4'hC;
    localparam logic [3:0] OP_MUL = 4'hD;
    localparam logic [3:0] OP_CMP = 4'hE;
    localparam logic [3:0] OP_IMM = 4'hF;

    // Sub-opcodes of OP_SYS (IR[11:8])
    localparam logic [3:0] SUB_NOP = 4'h0;
    localparam logic [3:0] SUB_HLT = 4'h1;
    localparam logic [3:0] SUB_CCF = 4'h2;
    localparam logic [3:0] SUB_SCF = 4'h3;
    localparam logic [3:0] SUB_BRZ = 4'h4;
    localparam logic [3:0] SUB_BRC = 4'h5;

    // Sub-opcodes of OP_IMM (IR[9:8])
    localparam logic [1:0] SUB_MIL = 2'd0;
    localparam logic [1:0] SUB_MIH = 2'd1;
    localparam logic [1:0] SUB_JPR = 2'd2;
    localparam logic [1:0] SUB_JPA = 2'd3;

    typedef struct packed {
        logic reset_pc;
        logic pc_plus_i;
        logic pc_plus_1;
        logic r_plus_i;
        logic r_plus_0;
        logic enable_pc;
        logic rs_on_addr_r;
        logic rd_on_addr_r;
        logic rfright_on_opnd;
        logic ir_on_lopnd;
        logic ir_on_hopnd;
        logic b15to0;
        logic a_and_b;
        logic a_or_b;
        logic not_b;
        logic shl_b;
        logic shr_b;
        logic a_add_b;
        logic a_sub_b;
        logic a_mul_b;
        logic a_cmp_b;
        logic sel_aluout_rfin;
        logic sel_rfin;
        logic rfl_write;
        logic rfh_write;
        logic ir_load;
        logic sr_load;
        logic c_set;
        logic c_reset;
        logic read_mem;
        logic write_mem;
        logic read_io;
        logic write_io;
    } ctrl_t;

    // Opcodes that own the bus for a variable number of cycles
    function automatic logic is_mem_op(input logic [3:0] opc);
        return (opc == OP_LDA) || (opc == OP_STA) ||
               (opc == OP_INP) || (opc == OP_OUT);
    endfunction

    function automatic logic is_hlt_op(input logic [3:0] opc, input logic [3:0] sub);
        return (opc == OP_SYS) && (sub == SUB_HLT);
    endfunction

endpackage

// File: rtl/sayeh_decoder.sv
// sayeh_decoder: purely combinational control decode.
// Ports:
//   state        in   current FSM state
//   instruction  in   IR contents
//   cout, zout   in   carry / zero flags from the datapath
//   memdataready in   bus access-complete handshake
//   ctrl         out  every datapath / bus strobe for this cycle
//   mem_op       out  current IR is LDA/STA/INP/OUT
//   hlt_op       out  current IR is HLT
module sayeh_decoder
    import sayeh_pkg::*;
(
    input  logic [2:0]  state,
    input  logic [15:0] instruction,
    input  logic        cout,
    input  logic        zout,
    input  logic        memdataready,
    output ctrl_t       ctrl,
    output logic        mem_op,
    output logic        hlt_op
);

    logic [3:0] opc_s;
    logic [3:0] sys_sub_s;
    logic [1:0] imm_sub_s;
    logic       write_ok_s;
    ctrl_t      ctrl_s;
    // The immediate is consumed by the datapath only; it never steers control.
    logic       unused_imm_s;

    assign opc_s        = instruction[OPC_MSB:OPC_LSB];
    assign sys_sub_s    = instruction[SYS_SUB_MSB:SYS_SUB_LSB];
    assign imm_sub_s    = instruction[IMM_SUB_MSB:IMM_SUB_LSB];
    assign unused_imm_s = ^instruction[IMM_MSB:IMM_LSB];
    assign mem_op       = is_mem_op(opc_s);
    assign hlt_op       = is_hlt_op(opc_s, sys_sub_s);
    assign ctrl         = ctrl_s;

    // Map (state, IR, flags, handshake) onto the strobe bundle.
    always_comb begin
        ctrl_s     = '0;
        // In MEMX the register file is only written in the completing cycle.
        write_ok_s = (state != ST_MEMX) || memdataready;
        case (state)
            ST_RST: begin
                ctrl_s.reset_pc  = 1'b1;
                ctrl_s.enable_pc = 1'b1;
            end
            ST_FETCH: begin
                ctrl_s.read_mem = 1'b1;
                ctrl_s.ir_load  = memdataready;
            end
            ST_DECODE: begin
                ctrl_s.pc_plus_1 = 1'b1;
                ctrl_s.enable_pc = 1'b1;
            end
            ST_EXEC, ST_MEMX: begin
                case (opc_s)
                    OP_SYS: begin
                        case (sys_sub_s)
                            SUB_CCF: ctrl_s.c_reset = 1'b1;
                            SUB_SCF: ctrl_s.c_set   = 1'b1;
                            SUB_BRZ: begin
                                ctrl_s.pc_plus_i = zout;
                                ctrl_s.enable_pc = zout;
                            end
                            SUB_BRC: begin
                                ctrl_s.pc_plus_i = cout;
                                ctrl_s.enable_pc = cout;
                            end
                            default: ctrl_s.c_set = 1'b0;
                        endcase
                    end
                    OP_MVR: begin
                        ctrl_s.rfright_on_opnd = 1'b1;
                        ctrl_s.b15to0          = 1'b1;
                        ctrl_s.sel_aluout_rfin = 1'b1;
                        ctrl_s.rfl_write       = 1'b1;
                        ctrl_s.rfh_write       = 1'b1;
                    end
                    OP_LDA: begin
                        ctrl_s.r_plus_0     = 1'b1;
                        ctrl_s.rs_on_addr_r = 1'b1;
                        ctrl_s.read_mem     = 1'b1;
                        ctrl_s.rfl_write    = 1'b1;
                        ctrl_s.rfh_write    = 1'b1;
                    end
                    OP_STA: begin
                        ctrl_s.r_plus_0        = 1'b1;
                        ctrl_s.rd_on_addr_r    = 1'b1;
                        ctrl_s.rfright_on_opnd = 1'b1;
                        ctrl_s.b15to0          = 1'b1;
                        ctrl_s.write_mem       = 1'b1;
                    end
                    OP_INP: begin
                        ctrl_s.read_io   = 1'b1;
                        ctrl_s.sel_rfin  = 1'b1;
                        ctrl_s.rfl_write = 1'b1;
                        ctrl_s.rfh_write = 1'b1;
                    end
                    OP_OUT: begin
                        ctrl_s.rfright_on_opnd = 1'b1;
                        ctrl_s.b15to0          = 1'b1;
                        ctrl_s.write_io        = 1'b1;
                    end
                    OP_AND, OP_ORR, OP_NOT, OP_SHL, OP_SHR, OP_ADD, OP_SUB, OP_MUL: begin
                        ctrl_s.a_and_b         = (opc_s == OP_AND);
                        ctrl_s.a_or_b          = (opc_s == OP_ORR);
                        ctrl_s.not_b           = (opc_s == OP_NOT);
                        ctrl_s.shl_b           = (opc_s == OP_SHL);
                        ctrl_s.shr_b           = (opc_s == OP_SHR);
                        ctrl_s.a_add_b         = (opc_s == OP_ADD);
                        ctrl_s.a_sub_b         = (opc_s == OP_SUB);
                        ctrl_s.a_mul_b         = (opc_s == OP_MUL);
                        ctrl_s.rfright_on_opnd = 1'b1;
                        ctrl_s.sel_aluout_rfin = 1'b1;
                        ctrl_s.rfl_write       = 1'b1;
                        ctrl_s.rfh_write       = 1'b1;
                        ctrl_s.sr_load         = 1'b1;
                    end
                    OP_CMP: begin
                        ctrl_s.a_cmp_b         = 1'b1;
                        ctrl_s.rfright_on_opnd = 1'b1;
                        ctrl_s.sel_aluout_rfin = 1'b1;
                        ctrl_s.sr_load         = 1'b1;
                    end
                    OP_IMM: begin
                        case (imm_sub_s)
                            SUB_MIL: begin
                                ctrl_s.ir_on_lopnd     = 1'b1;
                                ctrl_s.b15to0          = 1'b1;
                                ctrl_s.sel_aluout_rfin = 1'b1;
                                ctrl_s.rfl_write       = 1'b1;
                            end
                            SUB_MIH: begin
                                ctrl_s.ir_on_hopnd     = 1'b1;
                                ctrl_s.b15to0          = 1'b1;
                                ctrl_s.sel_aluout_rfin = 1'b1;
                                ctrl_s.rfh_write       = 1'b1;
                            end
                            SUB_JPR: begin
                                ctrl_s.pc_plus_i = 1'b1;
                                ctrl_s.enable_pc = 1'b1;
                            end
                            SUB_JPA: begin
                                ctrl_s.r_plus_i     = 1'b1;
                                ctrl_s.rd_on_addr_r = 1'b1;
                                ctrl_s.enable_pc    = 1'b1;
                            end
                            default: ctrl_s.enable_pc = 1'b0;
                        endcase
                    end
                    default: ctrl_s.enable_pc = 1'b0;
                endcase
                ctrl_s.rfl_write = ctrl_s.rfl_write & write_ok_s;
                ctrl_s.rfh_write = ctrl_s.rfh_write & write_ok_s;
            end
            ST_HALT: ctrl_s.enable_pc = 1'b0;
            default: ctrl_s.enable_pc = 1'b0;
        endcase
    end

endmodule

// File: rtl/sayeh_controller.sv
// sayeh_controller: multi-cycle control unit of the SAYEH CPU.
// Holds the fetch/decode/execute FSM and the bus-timeout watchdog; all
// strobes come combinationally from sayeh_decoder.
// Ports:
//   clk, rst_n                    clock, synchronous active-low reset
//   Instruction, Cout, Zout       IR and status flags from the datapath
//   memdataready                  memory/IO access-complete handshake
//   address-unit, bus-steering, ALU-select, register and bus strobes (outputs)
//   halted                        core stopped by HLT
//   bus_error                     core stopped by watchdog timeout
module sayeh_controller
    import sayeh_pkg::*;
#(
    parameter int WAIT_LIMIT = 255,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] Instruction,
    input  logic        Cout,
    input  logic        Zout,
    input  logic        memdataready,
    output logic        ResetPC,
    output logic        PCplusI,
    output logic        PCplus1,
    output logic        RplusI,
    output logic        Rplus0,
    output logic        EnablePC,
    output logic        Rs_on_AddressUnitRSide,
    output logic        Rd_on_AddressUnitRSide,
    output logic        RFright_on_OpndBus,
    output logic        IR_on_LOpndBus,
    output logic        IR_on_HOpndBus,
    output logic        B15to0,
    output logic        AandB,
    output logic        AorB,
    output logic        notB,
    output logic        shlB,
    output logic        shrB,
    output logic        AaddB,
    output logic        AsubB,
    output logic        AmulB,
    output logic        AcmpB,
    output logic        sel_aluout_rfin,
    output logic        sel_rfin,
    output logic        RFLwrite,
    output logic        RFHwrite,
    output logic        IRload,
    output logic        SRload,
    output logic        Cset,
    output logic        Creset,
    output logic        ReadMem,
    output logic        WriteMem,
    output logic        ReadIO,
    output logic        WriteIO,
    output logic        halted,
    output logic        bus_error
);

    localparam logic             WDOG_ON  = (WAIT_LIMIT != 0);
    // Timeout fires on the waiting cycle that would bring the count to WAIT_LIMIT.
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(WAIT_LIMIT - 1);

    logic [2:0]       state_r;
    logic [2:0]       state_nx_s;
    logic [CNT_W-1:0] wait_cnt_r;
    logic             halted_r;
    logic             bus_error_r;
    logic             waiting_s;
    logic             timeout_s;
    logic             mem_op_s;
    logic             hlt_op_s;
    ctrl_t            ctrl_s;

    sayeh_decoder u_decoder (
        .state        (state_r),
        .instruction  (Instruction),
        .cout         (Cout),
        .zout         (Zout),
        .memdataready (memdataready),
        .ctrl         (ctrl_s),
        .mem_op       (mem_op_s),
        .hlt_op       (hlt_op_s)
    );

    assign waiting_s = ((state_r == ST_FETCH) || (state_r == ST_MEMX)) && !memdataready;
    assign timeout_s = WDOG_ON && waiting_s && (wait_cnt_r == LIMIT_M1);

    // Next-state selection.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_RST:    state_nx_s = ST_FETCH;
            ST_FETCH: begin
                if (timeout_s) begin
                    state_nx_s = ST_HALT;
                end else if (memdataready) begin
                    state_nx_s = ST_DECODE;
                end else begin
                    state_nx_s = ST_FETCH;
                end
            end
            ST_DECODE: state_nx_s = mem_op_s ? ST_MEMX : ST_EXEC;
            ST_EXEC:   state_nx_s = hlt_op_s ? ST_HALT : ST_FETCH;
            ST_MEMX: begin
                if (timeout_s) begin
                    state_nx_s = ST_HALT;
                end else if (memdataready) begin
                    state_nx_s = ST_FETCH;
                end else begin
                    state_nx_s = ST_MEMX;
                end
            end
            ST_HALT:   state_nx_s = ST_HALT;
            default:   state_nx_s = ST_RST;
        endcase
    end

    // State, wait counter and sticky stop flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_RST;
            wait_cnt_r  <= '0;
            halted_r    <= 1'b0;
            bus_error_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if ((state_nx_s != state_r) || memdataready) begin
                wait_cnt_r <= '0;
            end else if (waiting_s) begin
                wait_cnt_r <= wait_cnt_r + CNT_W'(1);
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
            if ((state_r == ST_EXEC) && hlt_op_s) begin
                halted_r <= 1'b1;
            end else begin
                halted_r <= halted_r;
            end
            if (timeout_s) begin
                bus_error_r <= 1'b1;
            end else begin
                bus_error_r <= bus_error_r;
            end
        end
    end

    assign ResetPC                = ctrl_s.reset_pc;
    assign PCplusI                = ctrl_s.pc_plus_i;
    assign PCplus1                = ctrl_s.pc_plus_1;
    assign RplusI                 = ctrl_s.r_plus_i;
    assign Rplus0                 = ctrl_s.r_plus_0;
    assign EnablePC               = ctrl_s.enable_pc;
    assign Rs_on_AddressUnitRSide = ctrl_s.rs_on_addr_r;
    assign Rd_on_AddressUnitRSide = ctrl_s.rd_on_addr_r;
    assign RFright_on_OpndBus     = ctrl_s.rfright_on_opnd;
    assign IR_on_LOpndBus         = ctrl_s.ir_on_lopnd;
    assign IR_on_HOpndBus         = ctrl_s.ir_on_hopnd;
    assign B15to0                 = ctrl_s.b15to0;
    assign AandB                  = ctrl_s.a_and_b;
    assign AorB                   = ctrl_s.a_or_b;
    assign notB                   = ctrl_s.not_b;
    assign shlB                   = ctrl_s.shl_b;
    assign shrB                   = ctrl_s.shr_b;
    assign AaddB                  = ctrl_s.a_add_b;
    assign AsubB                  = ctrl_s.a_sub_b;
    assign AmulB                  = ctrl_s.a_mul_b;
    assign AcmpB                  = ctrl_s.a_cmp_b;
    assign sel_aluout_rfin        = ctrl_s.sel_aluout_rfin;
    assign sel_rfin               = ctrl_s.sel_rfin;
    assign RFLwrite               = ctrl_s.rfl_write;
    assign RFHwrite               = ctrl_s.rfh_write;
    assign IRload                 = ctrl_s.ir_load;
    assign SRload                 = ctrl_s.sr_load;
    assign Cset                   = ctrl_s.c_set;
    assign Creset                 = ctrl_s.c_reset;
    assign ReadMem                = ctrl_s.read_mem;
    assign WriteMem               = ctrl_s.write_mem;
    assign ReadIO                 = ctrl_s.read_io;
    assign WriteIO                = ctrl_s.write_io;
    assign halted                 = halted_r;
    assign bus_error              = bus_error_r;

endmodule

// File: tb/tb_sayeh_controller.sv
// tb_sayeh_controller: directed + randomized bench for sayeh_controller.
// The reference model walks each instruction through its fetch / decode /
// execute-or-access timeline and predicts the full strobe set per cycle.
module tb_sayeh_controller;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        cout, zout, mdr;

    logic ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC;
    logic Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide, RFright_on_OpndBus;
    logic IR_on_LOpndBus, IR_on_HOpndBus;
    logic B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB;
    logic sel_aluout_rfin, sel_rfin, RFLwrite, RFHwrite, IRload, SRload, Cset, Creset;
    logic ReadMem, WriteMem, ReadIO, WriteIO, halted, bus_error;

    always #5 clk = ~clk;

    sayeh_controller #(.WAIT_LIMIT(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .Instruction(instr), .Cout(cout), .Zout(zout),
        .memdataready(mdr),
        .ResetPC(ResetPC), .PCplusI(PCplusI), .PCplus1(PCplus1), .RplusI(RplusI),
        .Rplus0(Rplus0), .EnablePC(EnablePC),
        .Rs_on_AddressUnitRSide(Rs_on_AddressUnitRSide),
        .Rd_on_AddressUnitRSide(Rd_on_AddressUnitRSide),
        .RFright_on_OpndBus(RFright_on_OpndBus), .IR_on_LOpndBus(IR_on_LOpndBus),
        .IR_on_HOpndBus(IR_on_HOpndBus), .B15to0(B15to0), .AandB(AandB), .AorB(AorB),
        .notB(notB), .shlB(shlB), .shrB(shrB), .AaddB(AaddB), .AsubB(AsubB),
        .AmulB(AmulB), .AcmpB(AcmpB), .sel_aluout_rfin(sel_aluout_rfin),
        .sel_rfin(sel_rfin), .RFLwrite(RFLwrite), .RFHwrite(RFHwrite), .IRload(IRload),
        .SRload(SRload), .Cset(Cset), .Creset(Creset), .ReadMem(ReadMem),
        .WriteMem(WriteMem), .ReadIO(ReadIO), .WriteIO(WriteIO),
        .halted(halted), .bus_error(bus_error)
    );

    // Observed vector: {halted, bus_error, 33 strobes}
    logic [34:0] obs;
    assign obs = {halted, bus_error,
                  ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC,
                  Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide, RFright_on_OpndBus,
                  IR_on_LOpndBus, IR_on_HOpndBus, B15to0,
                  AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB,
                  sel_aluout_rfin, sel_rfin, RFLwrite, RFHwrite, IRload, SRload,
                  Cset, Creset, ReadMem, WriteMem, ReadIO, WriteIO};

    localparam logic [34:0] ONE      = 35'd1;
    localparam logic [34:0] M_HALTED = ONE << 34;
    localparam logic [34:0] M_BUSERR = ONE << 33;
    localparam logic [34:0] M_RSTPC  = ONE << 32;
    localparam logic [34:0] M_PCI    = ONE << 31;
    localparam logic [34:0] M_PC1    = ONE << 30;
    localparam logic [34:0] M_RI     = ONE << 29;
    localparam logic [34:0] M_R0     = ONE << 28;
    localparam logic [34:0] M_ENPC   = ONE << 27;
    localparam logic [34:0] M_RSAU   = ONE << 26;
    localparam logic [34:0] M_RDAU   = ONE << 25;
    localparam logic [34:0] M_RFR    = ONE << 24;
    localparam logic [34:0] M_IRL    = ONE << 23;
    localparam logic [34:0] M_IRH    = ONE << 22;
    localparam logic [34:0] M_B15    = ONE << 21;
    localparam logic [34:0] M_CMP    = ONE << 12;
    localparam logic [34:0] M_SELALU = ONE << 11;
    localparam logic [34:0] M_SELRF  = ONE << 10;
    localparam logic [34:0] M_RFL    = ONE << 9;
    localparam logic [34:0] M_RFH    = ONE << 8;
    localparam logic [34:0] M_IRLOAD = ONE << 7;
    localparam logic [34:0] M_SRLOAD = ONE << 6;
    localparam logic [34:0] M_CSET   = ONE << 5;
    localparam logic [34:0] M_CRESET = ONE << 4;
    localparam logic [34:0] M_RDMEM  = ONE << 3;
    localparam logic [34:0] M_WRMEM  = ONE << 2;
    localparam logic [34:0] M_RDIO   = ONE << 1;
    localparam logic [34:0] M_WRIO   = ONE;
    localparam logic [34:0] M_FULLW  = M_RFL | M_RFH;
    localparam logic [34:0] M_RST    = M_RSTPC | M_ENPC;

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string tag, input logic [34:0] got, input logic [34:0] exp);
        total_cnt++;
        assert (got === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Strobes an instruction asserts while executing / accessing.
    // ALU ops 6..13 select AandB..AmulB, which sit at bits 20 down to 13.
    function automatic logic [34:0] op_mask(input logic [15:0] ir, input logic c, input logic z);
        logic [3:0] opc;
        logic [3:0] sub;
        opc = ir[15:12];
        sub = ir[11:8];
        if (opc == 4'h0) begin
            if (sub == 4'h2) return M_CRESET;
            if (sub == 4'h3) return M_CSET;
            if (sub == 4'h4) return z ? (M_PCI | M_ENPC) : 35'd0;
            if (sub == 4'h5) return c ? (M_PCI | M_ENPC) : 35'd0;
            return 35'd0;
        end
        if (opc == 4'h1) return M_RFR | M_B15 | M_SELALU | M_FULLW;
        if (opc == 4'h2) return M_R0 | M_RSAU | M_RDMEM | M_FULLW;
        if (opc == 4'h3) return M_R0 | M_RDAU | M_RFR | M_B15 | M_WRMEM;
        if (opc == 4'h4) return M_RDIO | M_SELRF | M_FULLW;
        if (opc == 4'h5) return M_RFR | M_B15 | M_WRIO;
        if (opc >= 4'h6 && opc <= 4'hD)
            return (ONE << (26 - int'(opc))) | M_RFR | M_SELALU | M_FULLW | M_SRLOAD;
        if (opc == 4'hE) return M_CMP | M_RFR | M_SELALU | M_SRLOAD;
        case (ir[9:8])
            2'd0:    return M_IRL | M_B15 | M_SELALU | M_RFL;
            2'd1:    return M_IRH | M_B15 | M_SELALU | M_RFH;
            2'd2:    return M_PCI | M_ENPC;
            default: return M_RI | M_RDAU | M_ENPC;
        endcase
    endfunction

    function automatic logic is_access(input logic [15:0] ir);
        return ir[15:12] >= 4'h2 && ir[15:12] <= 4'h5;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, then release; returns in the first FETCH cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        mdr   = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("reset_state", obs, M_RST);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic fetch_phase(input int waits);
        for (int k = 0; k <= waits; k++) begin
            mdr = (k == waits);
            @(negedge clk);
            chk("fetch", obs, M_RDMEM | (mdr ? M_IRLOAD : 35'd0));
            next_cycle();
        end
    endtask

    task automatic decode_phase();
        mdr = 1'($urandom);
        @(negedge clk);
        chk("decode", obs, M_PC1 | M_ENPC);
        next_cycle();
    endtask

    // Full instruction timeline; returns at the start of the next FETCH.
    task automatic run_instr(input logic [15:0] ir, input int fw, input int mw,
                             input logic c, input logic z);
        logic [34:0] m;
        instr = ir;
        cout  = c;
        zout  = z;
        m     = op_mask(ir, c, z);
        fetch_phase(fw);
        decode_phase();
        if (is_access(ir)) begin
            for (int k = 0; k <= mw; k++) begin
                mdr = (k == mw);
                @(negedge clk);
                chk("memx", obs, mdr ? m : (m & ~M_FULLW));
                next_cycle();
            end
        end else begin
            mdr = 1'($urandom);
            @(negedge clk);
            chk("exec", obs, m);
            next_cycle();
        end
    endtask

    initial begin
        logic [15:0] v;
        rst_n = 1'b0;
        instr = 16'h0000;
        cout  = 1'b0;
        zout  = 1'b0;
        mdr   = 1'b0;

        do_reset();
        run_instr(16'hB600, 0, 0, 1'b0, 1'b0);   // ADD R1,R2
        run_instr(16'h2100, 0, 3, 1'b0, 1'b0);   // LDA with 3 wait cycles
        run_instr(16'h04FE, 1, 0, 1'b0, 1'b1);   // BRZ taken
        run_instr(16'h04FE, 0, 0, 1'b1, 1'b0);   // BRZ not taken
        run_instr(16'h05FE, 0, 0, 1'b1, 1'b0);   // BRC taken
        run_instr(16'hF300, 2, 0, 1'b0, 1'b0);   // JPA
        run_instr(16'h4800, 0, 2, 1'b0, 1'b0);   // INP
        run_instr(16'h5C00, 0, 1, 1'b0, 1'b0);   // OUT

        for (int i = 0; i < 50; i++) begin
            v = 16'($urandom);
            if (v[15:8] == 8'h01) v[8] = 1'b0;   // keep HLT out of the random mix
            run_instr(v, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom));
        end

        // Watchdog: handshake stuck low in FETCH.
        do_reset();
        mdr = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("wdog_wait", obs, M_RDMEM);
            next_cycle();
        end
        for (int k = 0; k < 3; k++) begin
            mdr = 1'($urandom);
            @(negedge clk);
            chk("wdog_halt", obs, M_BUSERR);
            next_cycle();
        end

        // HLT stops the core until reset.
        do_reset();
        run_instr(16'h0100, 0, 0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            mdr = 1'($urandom);
            @(negedge clk);
            chk("hlt_hold", obs, M_HALTED);
            next_cycle();
        end

        // Reset in the middle of a STA access aborts it.
        do_reset();
        instr = 16'h3400;
        fetch_phase(0);
        decode_phase();
        mdr = 1'b0;
        @(negedge clk);
        chk("sta_memx", obs, op_mask(16'h3400, 1'b0, 1'b0));
        rst_n = 1'b0;
        mdr   = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("sta_abort", obs, M_RST);
        rst_n = 1'b1;
        next_cycle();
        run_instr(16'h1500, 0, 0, 1'b0, 1'b0);   // MVR after recovery

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL tb_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/sayeh_controller.md
Name: sayeh_controller

Overview:
- Multi-cycle control unit for the SAYEH CPU; sits directly upstream of the datapath.
- Consumes the datapath's Instruction, Cout and Zout, and produces every datapath control strobe plus the memory/IO handshake strobes.
- Sequences fetch → decode → execute, with wait states on memory and IO accesses and a bus-timeout watchdog.

Parameters:
WAIT_LIMIT, 255, max cycles to wait for memdataready in one access; 0 disables the watchdog.
CNT_W, 8, width of the wait counter; must satisfy WAIT_LIMIT < 2**CNT_W.

Ports:
clk  in  1  system clock; all state changes on rising edge
rst_n  in  1  synchronous, active-low reset
Instruction  in  16  IR contents from datapath
Cout, Zout  in  1 each  status flags from datapath
memdataready  in  1  memory/IO access-complete handshake
ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC  out  1 each  address-unit controls
Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide, RFright_on_OpndBus, IR_on_LOpndBus, IR_on_HOpndBus  out  1 each  bus steering
B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB  out  1 each  ALU function select; at most one high
sel_aluout_rfin, sel_rfin, RFLwrite, RFHwrite, IRload, SRload, Cset, Creset  out  1 each  register and mux controls
ReadMem, WriteMem, ReadIO, WriteIO  out  1 each  bus strobes, held for the whole access
halted  out  1  core stopped by HLT
bus_error  out  1  core stopped by watchdog timeout

Behaviour:

Reset and state:
- rst_n low at a rising edge: state=RST, wait counter=0, halted=0, bus_error=0.
- All outputs are combinational from state, IR and flags.
- In RST: ResetPC=EnablePC=1, all other outputs 0.
- States: RST, FETCH, DECODE, EXEC, MEMX, HALT.

Transitions:
- RST → FETCH: first edge with rst_n high.
- FETCH: ReadMem=1; IRload=memdataready. On memdataready → DECODE; otherwise stay and count.
- DECODE: PCplus1=EnablePC=1 (PC advances by one) → EXEC.
  - Exception: opcode LDA/STA/INP/OUT → MEMX.
- EXEC: asserts the op's controls for one cycle → FETCH.
  - Exception: HLT → HALT.
- MEMX: holds the op's controls. Register/IR writes are asserted only in the cycle memdataready=1; then → FETCH.
- HALT: all outputs 0, halted=1; left only by reset.

Instruction fields and operand paths:
- Opcode is IR[15:12]; Rd=IR[11:10], Rs=IR[9:8]; imm=IR[7:0].
- Full-register write = RFLwrite+RFHwrite.
- Register/ALU ops below assert sel_aluout_rfin=1 and, when a source operand is used, RFright_on_OpndBus=1.

Opcode decode (unlisted codes execute as NOP):
- 0000, sub IR[11:8]:
  - 0 NOP.
  - 1 HLT.
  - 2 CCF: Creset.
  - 3 SCF: Cset.
  - 4 BRZ: if Zout, PCplusI+EnablePC; else nothing.
  - 5 BRC: same as BRZ, tested on Cout.
  - 6–15 NOP.
- 0001 MVR: B15to0, full write.
- 0010 LDA: Rplus0, Rs_on_AddressUnitRSide, ReadMem, sel_aluout_rfin=0, sel_rfin=0, full write.
- 0011 STA: Rplus0, Rd_on_AddressUnitRSide, RFright_on_OpndBus, B15to0, WriteMem.
- 0100 INP: ReadIO, sel_rfin=1, full write.
- 0101 OUT: RFright_on_OpndBus, B15to0, WriteIO.
- 0110 AND (AandB), 0111 ORR (AorB), 1000 NOT (notB), 1001 SHL (shlB), 1010 SHR (shrB), 1011 ADD (AaddB), 1100 SUB (AsubB), 1101 MUL (AmulB): full write + SRload.
- 1110 CMP: AcmpB, SRload, no register write.
- 1111, sub IR[9:8]:
  - 00 MIL: IR_on_LOpndBus, B15to0, sel_aluout_rfin, RFLwrite.
  - 01 MIH: IR_on_HOpndBus, B15to0, sel_aluout_rfin, RFHwrite.
  - 10 JPR: PCplusI+EnablePC.
  - 11 JPA: RplusI, Rd_on_AddressUnitRSide, EnablePC.

Relative branch arithmetic:
- PC-relative targets use the already-incremented PC plus sign-extended imm; wrap is modulo 2^16.

Watchdog:
- Counter increments each FETCH/MEMX cycle with memdataready=0.
- Counter clears on state entry and on memdataready.
- Reaching WAIT_LIMIT (WAIT_LIMIT≠0) → HALT with bus_error=1; strobes drop the next cycle.

Boundary conditions:
- memdataready outside FETCH/MEMX is ignored.
- rst_n low in any state, including mid-MEMX, aborts the access; strobes deassert after that edge.

Decomposition:
- Package sayeh_pkg holds the state encoding, the opcode and sub-opcode constants, and the field bit positions.
- One sub-module, sayeh_decoder: purely combinational mapping from (state, IR, Cout, Zout, memdataready) to control outputs.
- The top level holds the FSM and the watchdog counter.

Test Plan:
- Reset release, memdataready tied 1 → RST 1 cycle (ResetPC=EnablePC=1), then FETCH with ReadMem=IRload=1, DECODE with PCplus1=1.
- IR=16'hB600 (ADD R1,R2), EXEC → AaddB=RFright_on_OpndBus=sel_aluout_rfin=RFLwrite=RFHwrite=SRload=1, next state FETCH.
- IR=16'h2100 (LDA R0,[R1]), memdataready low 3 cycles → ReadMem held 4 MEMX cycles, RFLwrite/RFHwrite only in the 4th.
- IR=16'h04FE (BRZ -2): Zout=1 → PCplusI=EnablePC=1; Zout=0 → all PC controls 0.
- WAIT_LIMIT=4, memdataready stuck 0 in FETCH → bus_error=1 and halted=0 after 4 waiting cycles, all strobes 0 after.
- IR=16'h0100 (HLT) → halted=1 and persists; rst_n low mid-MEMX of STA → WriteMem drops after the edge, state RST.
